mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator between the CPU execute stage and port B of the shared dual-port BRAM main memory. It accepts one load or store request at a time, issues word-aligned accesses with per-byte enables, and captures the one-cycle-latency read data. For loads it extracts and sign- or zero-extends the result. Misaligned accesses are either split into two word accesses or faulted, selected at compile time.

## Interface
- MEM_SIZE, 8192: bytes of backing memory; memory-side address width is $clog2(MEM_SIZE).
- clk  in  1  rising-edge clock shared with the memory.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on a cycle where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  zero-extend the load result when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse that completes the request.
- rsp_err  out  1  qualifies rsp_valid; the request faulted.
- rsp_rdata  out  32  formatted load data; 0 for stores and faults.
- mem_addr  out  $clog2(MEM_SIZE)  word address to memory port B; bits [1:0] are always 0.
- mem_wdata  out  32  memory port B write data.
- mem_be  out  4  memory port B byte enables.
- mem_we  out  1  memory port B write enable.
- mem_rdata  in  32  memory port B read data, valid one cycle after the address is presented.

## Operation
- The FSM has four states: IDLE, ISSUE0, ISSUE1, CAPT. The reset state is IDLE.
- Request registers are loaded on acceptance.
- nbytes is 1, 2 or 4. off = req_addr[1:0]. Base word address = req_addr with bits [1:0] cleared.
- A fault is raised on acceptance for any of these conditions, and no memory access occurs:
  - req_size = 3.
  - req_addr >= MEM_SIZE.
  - The access is split and base + 4 >= MEM_SIZE. Address wrap-around is never performed.
  - The access is misaligned and MISALIGNED_SPLIT_EN is undefined.
- A faulted request produces rsp_valid = 1 and rsp_err = 1 on the next cycle. The FSM stays in IDLE.
- An access is split when off + nbytes > 4.
- Byte mask: 8-bit mask = ((1 << nbytes) - 1) << off. Word0 takes mask[3:0]; word1 takes mask[7:4].
- Store data: the 64-bit value req_wdata << (8*off) is split into low and high words.
- Unsplit access: IDLE -> ISSUE0 -> CAPT -> IDLE.
- Split access: IDLE -> ISSUE0 -> ISSUE1 -> CAPT -> IDLE.
- Issue states drive mem_addr, mem_be, mem_wdata and mem_we (= stored write flag). ISSUE0 issues word0; ISSUE1 issues word1 at base + 4.
- In every other state: mem_we = 0, mem_be = 0.
- Read data capture:
  - ISSUE1 captures mem_rdata as word0.
  - CAPT captures the final word (word0 if unsplit, word1 if split).
  - CAPT also registers the response: rsp_valid = 1, rsp_err = 0.
- Load formatting: the 64-bit value {word1, word0} >> (8*off) is truncated to nbytes and then zero- or sign-extended.
- Stores still wait through CAPT so that all requests have uniform latency.
- Reset values: rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0. req_ready = 1 once rst_n is released.
- Reset asserted mid-access returns the FSM to IDLE and clears mem_we immediately (asynchronously). A partially written split store is not rolled back.

## Timing
- Accept at cycle N. ISSUE0 in N+1. Memory samples at the end of N+1.
- Unsplit: rsp_valid in N+3; req_ready high again in N+3.
- Split: ISSUE1 in N+2, rsp_valid in N+4.
- Fault: rsp_valid in N+1; req_ready stays high.
- A new request may be accepted in the same cycle that rsp_valid is high.
- rsp_* outputs are registered. mem_* outputs are registered or decoded from state only, with no combinational path from req_*.

## Configuration
- MISALIGNED_SPLIT_EN defined: the ISSUE1 path exists and misaligned half and word accesses complete as two word accesses.
- MISALIGNED_SPLIT_EN undefined: the ISSUE1 state and the word1 datapath are removed, and every misaligned access faults.

## Test plan
- Memory word 0x10 preloaded with 0x8899AABB. Load word at 0x10 -> rsp_rdata = 0x8899AABB, rsp_valid at N+3, mem_be = 4'hF, mem_we = 0.
- Load byte at 0x13: signed -> 0xFFFFFF88; unsigned -> 0x00000088.
- Store half 0xBEEF at 0x22 -> mem_be = 4'hC, mem_wdata = 0xBEEFxxxx. A subsequent load word at 0x20 returns 0xBEEF in bits [31:16] with bits [15:0] unchanged.
- With MISALIGNED_SPLIT_EN, store word 0x11223344 at 0x41 -> two writes: 0x40 with be = 4'hE, then 0x44 with be = 4'h1. A subsequent load word at 0x41 returns 0x11223344 with rsp_valid at N+4.
- Faults, each giving rsp_err = 1 at N+1 with mem_we never asserted:
  - req_size = 3.
  - Load word at MEM_SIZE - 2.
  - Misaligned word access without MISALIGNED_SPLIT_EN.
- Assert rst_n low during ISSUE1 of a split store -> mem_we = 0 in the same cycle, rsp_valid = 0, req_ready = 1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for BRAM port B with byte enables and load extension.
// Define MISALIGNED_SPLIT_EN to split misaligned accesses into two word accesses instead of faulting them.
module mem_access_unit #(
  parameter int MEM_SIZE = 8192
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [1:0]                  req_size,
  input  logic                        req_unsigned,
  input  logic [31:0]                 req_addr,
  input  logic [31:0]                 req_wdata,
  output logic                        rsp_valid,
  output logic                        rsp_err,
  output logic [31:0]                 rsp_rdata,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
  output logic [31:0]                 mem_wdata,
  output logic [3:0]                  mem_be,
  output logic                        mem_we,
  input  logic [31:0]                 mem_rdata
);
  localparam int AW = $clog2(MEM_SIZE);
`ifdef MISALIGNED_SPLIT_EN
  typedef enum logic [1:0] {IDLE, ISSUE0, ISSUE1, CAPT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE0, CAPT} state_t;
`endif
  state_t state;
  logic wr_q, uns_q;
  logic [1:0] size_q, off_q, off;
  logic [AW-1:0] base_q;
  logic [3:0] be0_q, be0, nb_mask;
  logic [31:0] wd0_q, wd0, sh, fmt;
  logic [63:0] rd64;
  logic fault;
  assign off = req_addr[1:0];
  assign nb_mask = req_size == 2'd0 ? 4'h1 : req_size == 2'd1 ? 4'h3 : 4'hF;
  assign req_ready = state == IDLE;
`ifdef MISALIGNED_SPLIT_EN
  logic split, split_q;
  logic [7:0] mask8;
  logic [63:0] wd64;
  logic [3:0] be1_q;
  logic [31:0] wd1_q, w0_q;
  assign mask8 = {4'h0, nb_mask} << off;
  assign wd64 = {32'h0, req_wdata} << {off, 3'b000};
  assign be0 = mask8[3:0];
  assign wd0 = wd64[31:0];
  // any enable spilling into the upper nibble means the access crosses a word boundary
  assign split = |mask8[7:4];
  assign fault = req_size == 2'd3 || req_addr >= 32'(MEM_SIZE) ||
                 (split && {req_addr[31:2], 2'b00} + 32'd4 >= 32'(MEM_SIZE));
  assign mem_we = (state == ISSUE0 || state == ISSUE1) && wr_q;
  assign mem_be = state == ISSUE0 ? be0_q : state == ISSUE1 ? be1_q : 4'h0;
  assign mem_addr = state == ISSUE1 ? base_q + AW'(4) : base_q;
  assign mem_wdata = state == ISSUE1 ? wd1_q : wd0_q;
  assign rd64 = split_q ? {mem_rdata, w0_q} : {32'h0, mem_rdata};
`else
  logic [1:0] align_mask;
  assign align_mask = req_size == 2'd0 ? 2'd0 : req_size == 2'd1 ? 2'd1 : 2'd3;
  assign be0 = nb_mask << off;
  assign wd0 = req_wdata << {off, 3'b000};
  assign fault = req_size == 2'd3 || req_addr >= 32'(MEM_SIZE) || |(off & align_mask);
  assign mem_we = state == ISSUE0 && wr_q;
  assign mem_be = state == ISSUE0 ? be0_q : 4'h0;
  assign mem_addr = base_q;
  assign mem_wdata = wd0_q;
  assign rd64 = {32'h0, mem_rdata};
`endif
  assign sh = 32'(rd64 >> {off_q, 3'b000});
  assign fmt = size_q == 2'd0 ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
               size_q == 2'd1 ? {{16{~uns_q & sh[15]}}, sh[15:0]} : sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= 2'd0;
      off_q <= 2'd0;
      base_q <= '0;
      be0_q <= 4'h0;
      wd0_q <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= 32'h0;
`ifdef MISALIGNED_SPLIT_EN
      split_q <= 1'b0;
      be1_q <= 4'h0;
      wd1_q <= 32'h0;
      w0_q <= 32'h0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          if (fault) begin
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            state <= ISSUE0;
            wr_q <= req_write;
            uns_q <= req_unsigned;
            size_q <= req_size;
            off_q <= off;
            base_q <= {req_addr[AW-1:2], 2'b00};
            be0_q <= be0;
            wd0_q <= wd0;
`ifdef MISALIGNED_SPLIT_EN
            split_q <= split;
            be1_q <= mask8[7:4];
            wd1_q <= wd64[63:32];
`endif
          end
        end
`ifdef MISALIGNED_SPLIT_EN
        ISSUE0: state <= split_q ? ISSUE1 : CAPT;
        ISSUE1: begin
          w0_q <= mem_rdata;
          state <= CAPT;
        end
`else
        ISSUE0: state <= CAPT;
`endif
        CAPT: begin
          state <= IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= wr_q ? 32'h0 : fmt;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized requests against a BRAM model,
// checked with a byte-addressed reference memory.
module tb_mem_access_unit;
  localparam int MEM_SIZE = 8192;
  localparam int WORDS = MEM_SIZE / 4;
  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_write, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  logic mem_we;
  typedef struct packed {logic we; logic [12:0] addr; logic [3:0] be; logic [31:0] wd;} iss_t;
  iss_t iss_q[$];
  logic [31:0] bram [WORDS];
  logic [7:0] ref_mem [MEM_SIZE];
  logic init_done = 1'b0;
  int wr_cnt = 0;
  int checks = 0;
  int errors = 0;

  mem_access_unit #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return i == 4 ? 32'h8899AABB : (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // BRAM port B: one-cycle read latency, byte-enabled writes, logs every issued access
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < WORDS; i++) bram[i] <= init_word(i);
      init_done <= 1'b1;
    end
    if (mem_be != 4'h0) iss_q.push_back({mem_we, mem_addr, mem_be, mem_wdata});
    if (mem_we) begin
      wr_cnt <= wr_cnt + 1;
      for (int b = 0; b < 4; b++) if (mem_be[b]) bram[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= bram[mem_addr[12:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    int n, lat, nexp, base_i, wc0, p;
    logic flt;
    logic [31:0] exp_rd;
    logic [12:0] ea [2];
    logic [3:0] eb [2];
    logic [31:0] ed [2];
    longint la;
    la = longint'(a);
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    flt = sz == 2'd3 || la >= MEM_SIZE || ((la % 4) + n > 4 && (la / 4) * 4 + 4 >= MEM_SIZE);
`ifndef MISALIGNED_SPLIT_EN
    if (la % n != 0) flt = 1'b1;
`endif
    exp_rd = '0;
    nexp = 0;
    if (!flt)
      for (int i = 0; i < n; i++) begin
        p = int'(la) + i;
        if (nexp == 0 || int'(ea[nexp-1]) != p / 4 * 4) begin
          ea[nexp] = 13'(p / 4 * 4);
          eb[nexp] = '0;
          ed[nexp] = '0;
          nexp++;
        end
        eb[nexp-1][p % 4] = 1'b1;
        ed[nexp-1][8*(p%4) +: 8] = wd[8*i +: 8];
        if (w) ref_mem[p] = wd[8*i +: 8];
        else exp_rd[8*i +: 8] = ref_mem[p];
      end
    if (!flt && !w && !u && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | ~((32'd1 << (8*n)) - 32'd1);
    chk({tag, ".ready_in"}, 32'(req_ready), 32'd1);
    base_i = iss_q.size();
    wc0 = wr_cnt;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk({tag, ".lat"}, 32'(lat), flt ? 32'd1 : nexp == 2 ? 32'd4 : 32'd3);
    chk({tag, ".err"}, 32'(rsp_err), 32'(flt));
    chk({tag, ".rdata"}, rsp_rdata, (w || flt) ? 32'h0 : exp_rd);
    chk({tag, ".ready_out"}, 32'(req_ready), 32'd1);
    chk({tag, ".n_issue"}, 32'(iss_q.size() - base_i), 32'(nexp));
    for (int k = 0; k < nexp && base_i + k < iss_q.size(); k++) begin
      chk({tag, ".addr"}, 32'(iss_q[base_i+k].addr), 32'(ea[k]));
      chk({tag, ".be"}, 32'(iss_q[base_i+k].be), 32'(eb[k]));
      chk({tag, ".we"}, 32'(iss_q[base_i+k].we), 32'(w));
      if (w) chk({tag, ".wdata"}, iss_q[base_i+k].wd & be_mask(eb[k]), ed[k]);
    end
    if (flt) chk({tag, ".no_write"}, 32'(wr_cnt - wc0), 32'd0);
  endtask

  initial begin
    logic [31:0] v, a;
    logic [1:0] sz;
    int sel;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int w = 0; w < WORDS; w++) begin
      v = init_word(w);
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = v[8*b +: 8];
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_be", 32'(mem_be), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    do_req("ldw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("ldw10.const", rsp_rdata, 32'h8899AABB);
    do_req("ldb13s", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    chk("ldb13s.const", rsp_rdata, 32'hFFFFFF88);
    do_req("ldb13u", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    chk("ldb13u.const", rsp_rdata, 32'h00000088);
    do_req("sth22", 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF);
    do_req("ldw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    chk("ldw20.hi", 32'(rsp_rdata[31:16]), 32'hBEEF);
    do_req("stw41", 1'b1, 2'd2, 1'b0, 32'h41, 32'h11223344);
    do_req("ldw41", 1'b0, 2'd2, 1'b0, 32'h41, 32'h0);
`ifdef MISALIGNED_SPLIT_EN
    chk("ldw41.const", rsp_rdata, 32'h11223344);
`else
    chk("ldw41.fault", 32'(rsp_err), 32'd1);
`endif
    do_req("flt_sz3", 1'b0, 2'd3, 1'b0, 32'h8, 32'h0);
    do_req("flt_end", 1'b0, 2'd2, 1'b0, 32'(MEM_SIZE - 2), 32'h0);
    do_req("flt_oob", 1'b1, 2'd0, 1'b0, 32'(MEM_SIZE), 32'h5);
    @(negedge clk);
    chk("rsp.pulse", 32'(rsp_valid), 32'd0);
    req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'hA1B2C3D4;
`ifdef MISALIGNED_SPLIT_EN
    req_addr = 32'h81;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid.we_before", 32'(mem_we), 32'd1);
    chk("mid.be_before", 32'(mem_be), 32'h1);
    for (int i = 0; i < 3; i++) ref_mem[32'h81 + i] = req_wdata[8*i +: 8];
`else
    req_addr = 32'h80;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("mid.we_before", 32'(mem_we), 32'd1);
    chk("mid.be_before", 32'(mem_be), 32'hF);
`endif
    rst_n = 1'b0;
    #1;
    chk("mid.we_rst", 32'(mem_we), 32'd0);
    chk("mid.be_rst", 32'(mem_be), 32'd0);
    chk("mid.valid_rst", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid.ready_rel", 32'(req_ready), 32'd1);
    chk("mid.valid_rel", 32'(rsp_valid), 32'd0);
    do_req("ld80", 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    do_req("ld84", 1'b0, 2'd2, 1'b0, 32'h84, 32'h0);
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      a = sel < 7 ? 32'($urandom_range(0, 127)) : sel < 9 ? 32'(MEM_SIZE - 12 + $urandom_range(0, 15)) : $urandom;
      sz = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      do_req("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    for (int t = 0; t < 32; t++) do_req("sweep", 1'b0, 2'd2, 1'b0, 32'(4 * t), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
